// File: rtl/dma_pkg.sv
// Shared DMA definitions: mode-word field positions, field encodings and default
// slave register addresses.
package dma_pkg;

    localparam int MODE_TT_LSB   = 0;
    localparam int MODE_AUTOINIT = 2;
    localparam int MODE_DEC      = 3;
    localparam int MODE_SVC_LSB  = 4;

    typedef enum logic [1:0] {
        XFER_VERIFY  = 2'b00,
        XFER_WRITE   = 2'b01,
        XFER_READ    = 2'b10,
        XFER_ILLEGAL = 2'b11
    } xfer_type_e;

    typedef enum logic [1:0] {
        SVC_DEMAND  = 2'b00,
        SVC_SINGLE  = 2'b01,
        SVC_BLOCK   = 2'b10,
        SVC_CASCADE = 2'b11
    } svc_mode_e;

    localparam int DEFAULT_MODE_ADDR  = 11;
    localparam int DEFAULT_CLEAR_ADDR = 13;

endpackage

// File: rtl/dma_mode_regfile_if.sv
// CPU slave bus of the DMA mode register file (8237-style strobes, active low).
interface dma_mode_regfile_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              cs_n;
    logic [ADDR_W-1:0] address_in;
    logic              IOR;
    logic              IOW;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;

    modport master (
        output cs_n, address_in, IOR, IOW, data_in,
        input  data_out, data_oe
    );

    modport slave (
        input  cs_n, address_in, IOR, IOW, data_in,
        output data_out, data_oe
    );
endinterface

// File: rtl/dma_strobe_edge.sv
// One-shot and release detector for an active-low bus strobe: fire on the first
// qualified cycle, done_pulse on the edge where the strobe returns high after one.
module dma_strobe_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_n,
    input  logic qual,
    output logic fire,
    output logic done_pulse
);
    logic seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        seen <= 1'b0;
        else if (strobe_n) seen <= 1'b0;
        else if (qual)     seen <= 1'b1;
    end

    assign fire       = qual & ~seen;
    assign done_pulse = strobe_n & seen;
endmodule

// File: rtl/dma_mode_regfile.sv
// Per-channel DMA mode register file with master clear, sequential read-back and
// auto-init reload strobe. Define MODE_LOCK_EN to defer writes to busy channels.
module dma_mode_regfile
    import dma_pkg::*;
#(
    parameter int                NUM_CH     = 4,
    parameter int                CH_W       = $clog2(NUM_CH),
    parameter int                MODE_W     = 6,
    parameter int                ADDR_W     = 4,
    parameter int                MODE_ADDR  = DEFAULT_MODE_ADDR,
    parameter int                CLEAR_ADDR = DEFAULT_CLEAR_ADDR,
    parameter logic [MODE_W-1:0] RESET_MODE = '0,
    parameter int                M2M_SRC_CH = 0,
    parameter int                M2M_DST_CH = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    dma_mode_regfile_if.slave   bus,
    input  logic [CH_W-1:0]     ch_select,
    input  logic                mem2mem,
    input  logic                flag_mem,
    input  logic                tc,
    input  logic [NUM_CH-1:0]   busy,
    output logic [MODE_W-1:0]   mode_out,
    output logic                autoinit_reload
);
    logic [MODE_W-1:0] mode     [NUM_CH];
    logic [MODE_W-1:0] mode_ext [2**CH_W];
    logic [CH_W-1:0]   ptr;

    logic [CH_W-1:0]   wr_ch;
    logic [MODE_W-1:0] wr_mode;
    logic              wr_qual, rd_qual, wr_fire, rd_done, unused_wr_done;
    logic              wr_ch_ok, wr_hit, clr_hit;

    assign wr_ch   = bus.data_in[CH_W-1:0];
    assign wr_mode = bus.data_in[MODE_W+CH_W-1:CH_W];
    assign wr_qual = ~bus.cs_n & ~bus.IOW & bus.IOR;
    assign rd_qual = ~bus.cs_n & ~bus.IOR & bus.IOW
                   & (bus.address_in == ADDR_W'(MODE_ADDR));

    dma_strobe_edge u_iow_edge (
        .clk(clk), .rst_n(rst_n), .strobe_n(bus.IOW), .qual(wr_qual),
        .fire(wr_fire), .done_pulse(unused_wr_done)
    );

    dma_strobe_edge u_ior_edge (
        .clk(clk), .rst_n(rst_n), .strobe_n(bus.IOR), .qual(rd_qual),
        .fire(), .done_pulse(rd_done)
    );

    // Pad the store to the full index range so every channel index is a legal select.
    for (genvar g = 0; g < 2**CH_W; g++) begin : g_ext
        if (g < NUM_CH) begin : g_real
            assign mode_ext[g] = mode[g];
        end else begin : g_pad
            assign mode_ext[g] = RESET_MODE;
        end
    end

    if (NUM_CH == 2**CH_W) begin : g_ch_full
        assign wr_ch_ok = 1'b1;
    end else begin : g_ch_part
        assign wr_ch_ok = (wr_ch < CH_W'(NUM_CH));
    end

    assign clr_hit = wr_fire & (bus.address_in == ADDR_W'(CLEAR_ADDR));
    assign wr_hit  = wr_fire & (bus.address_in == ADDR_W'(MODE_ADDR)) & wr_ch_ok;

`ifdef MODE_LOCK_EN
    logic              pend_valid;
    logic [CH_W-1:0]   pend_ch;
    logic [MODE_W-1:0] pend_mode;
`else
    logic unused_busy;
    assign unused_busy = ^busy;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode            <= '{default: RESET_MODE};
            ptr             <= '0;
            autoinit_reload <= 1'b0;
`ifdef MODE_LOCK_EN
            pend_valid      <= 1'b0;
            pend_ch         <= '0;
            pend_mode       <= '0;
`endif
        end else begin
            // mode_out still reflects the pre-write mode on this edge
            autoinit_reload <= tc & mode_out[MODE_AUTOINIT];
            if (clr_hit) begin
                mode <= '{default: RESET_MODE};
                ptr  <= '0;
`ifdef MODE_LOCK_EN
                pend_valid <= 1'b0;
`endif
            end else begin
                if (rd_done)
                    ptr <= (ptr == CH_W'(NUM_CH - 1)) ? '0 : ptr + CH_W'(1);
`ifdef MODE_LOCK_EN
                // Drain first so a new write on the same edge wins both the slot and the register.
                if (pend_valid && !busy[pend_ch]) begin
                    mode[pend_ch] <= pend_mode;
                    pend_valid    <= 1'b0;
                end
                if (wr_hit) begin
                    if (busy[wr_ch]) begin
                        pend_valid <= 1'b1;
                        pend_ch    <= wr_ch;
                        pend_mode  <= wr_mode;
                    end else begin
                        mode[wr_ch] <= wr_mode;
                    end
                end
`else
                if (wr_hit)
                    mode[wr_ch] <= wr_mode;
`endif
            end
        end
    end

    always_comb begin
        mode_out = mode_ext[ch_select];
        if (mem2mem)
            mode_out = flag_mem ? mode_ext[M2M_SRC_CH] : mode_ext[M2M_DST_CH];
    end

    assign bus.data_oe  = rd_qual & rst_n;
    assign bus.data_out = bus.data_oe ? {mode_ext[ptr], ptr} : '0;
endmodule

// File: tb/tb_dma_mode_regfile.sv
// Scoreboard bench for dma_mode_regfile (default parameters); covers MODE_LOCK_EN
// when the macro is defined for the build.
module tb_dma_mode_regfile;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] ch_select;
    logic       mem2mem, flag_mem, tc;
    logic [3:0] busy;
    logic [5:0] mode_out;
    logic       autoinit_reload;

    dma_mode_regfile_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    dma_mode_regfile dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .ch_select(ch_select),
        .mem2mem(mem2mem), .flag_mem(flag_mem), .tc(tc), .busy(busy),
        .mode_out(mode_out), .autoinit_reload(autoinit_reload)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [5:0]  mmode [4];
    int unsigned mptr;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [15:0] exp);
        sb_q.push_back('{tag, exp});
    endtask

    task automatic sb_pop_check(input logic [15:0] got);
        sb_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 16'(sb_q.size()), 16'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, got, e.exp);
        end
    endtask

    task automatic obs(input string tag, input logic [15:0] got, input logic [15:0] exp);
        sb_push(tag, exp);
        sb_pop_check(got);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After the first edge the data is changed; a repeated write would store the inverted mode.
    task automatic wr(input logic [3:0] a, input logic [7:0] d, input int unsigned hold);
        bus.cs_n = 1'b0; bus.address_in = a; bus.data_in = d; bus.IOW = 1'b0;
        tick();
        bus.data_in = d ^ 8'hFC;
        for (int unsigned k = 1; k < hold; k++) tick();
        bus.IOW = 1'b1; bus.cs_n = 1'b1; bus.data_in = '0;
        tick();
        if (a == 4'd11) mmode[d[1:0]] = d[7:2];
        else if (a == 4'd13) begin
            mmode = '{default: '0};
            mptr  = 0;
        end
    endtask

    task automatic rd(input string tag);
        bus.cs_n = 1'b0; bus.address_in = 4'd11; bus.IOR = 1'b0;
        #1;
        obs({tag, "_oe"}, 16'(bus.data_oe), 16'd1);
        obs(tag, 16'(bus.data_out), {8'h00, mmode[mptr], 2'(mptr)});
        tick();
        bus.IOR = 1'b1; bus.cs_n = 1'b1;
        tick();
        mptr = (mptr + 1) % 4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected one");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cs_n = 1'b1; bus.IOR = 1'b1; bus.IOW = 1'b1;
        bus.address_in = '0; bus.data_in = '0;
        ch_select = '0; mem2mem = 1'b0; flag_mem = 1'b0; tc = 1'b0; busy = '0;
        mmode = '{default: '0};
        mptr = 0;

        #12;
        obs("rst_oe", 16'(bus.data_oe), 16'd0);
        obs("rst_reload", 16'(autoinit_reload), 16'd0);
        obs("rst_mode", 16'(mode_out), 16'd0);
        rst_n = 1'b1;
        tick();

        // Read-back pointer walk and wrap from reset
        for (int i = 0; i < 5; i++) rd("rd_reset");

        // One write per strobe despite a 5-cycle IOW
        wr(4'd11, 8'hAA, 5);
        ch_select = 2'd2;
        #1;
        obs("wr_once", 16'(mode_out), 16'h2A);
        obs("idle_oe", 16'(bus.data_oe), 16'd0);
        obs("idle_data", 16'(bus.data_out), 16'd0);
        rd("rd_ch1");
        rd("rd_ch2");

        // Memory-to-memory source/destination selection
        wr(4'd11, 8'h14, 1);
        wr(4'd11, 8'h25, 1);
        mem2mem = 1'b1; flag_mem = 1'b1;
        #1;
        obs("m2m_src", 16'(mode_out), 16'h05);
        flag_mem = 1'b0;
        #1;
        obs("m2m_dst", 16'(mode_out), 16'h09);
        mem2mem = 1'b0;

        // Auto-init reload strobe
        wr(4'd11, 8'h11, 1);
        ch_select = 2'd1;
        tc = 1'b1;
        tick();
        tc = 1'b0;
        obs("reload_pulse", 16'(autoinit_reload), 16'd1);
        tick();
        obs("reload_end", 16'(autoinit_reload), 16'd0);
        tc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            obs("reload_held", 16'(autoinit_reload), 16'd1);
        end
        tc = 1'b0;
        tick();
        obs("reload_held_end", 16'(autoinit_reload), 16'd0);
        wr(4'd11, 8'h01, 1);
        tc = 1'b1;
        tick();
        tc = 1'b0;
        obs("reload_noauto", 16'(autoinit_reload), 16'd0);

        // Write of autoinit mode on the same edge as tc: decision uses the old mode
        bus.cs_n = 1'b0; bus.address_in = 4'd11; bus.data_in = 8'h11; bus.IOW = 1'b0; tc = 1'b1;
        tick();
        tc = 1'b0; bus.IOW = 1'b1; bus.cs_n = 1'b1; bus.data_in = '0;
        mmode[1] = 6'h04;
        obs("reload_prewrite", 16'(autoinit_reload), 16'd0);
        obs("reload_wr_applied", 16'(mode_out), 16'h04);
        tick();
        obs("reload_prewrite_end", 16'(autoinit_reload), 16'd0);

        // Master clear in the middle of a read-back sequence
        wr(4'd11, 8'hFC, 1);
        wr(4'd11, 8'h55, 1);
        wr(4'd11, 8'hAA, 1);
        wr(4'd11, 8'hCF, 1);
        for (int i = 0; i < 4 && mptr != 2; i++) rd("rd_prog");
        obs("ptr_at_2", 16'(mptr), 16'd2);
        wr(4'd13, 8'hFF, 2);
        for (int i = 0; i < 4; i++) begin
            ch_select = 2'(i);
            #1;
            obs("clr_mode", 16'(mode_out), 16'd0);
        end
        rd("rd_after_clr");

        // Simultaneous IOR and IOW low: neither a write nor a read
        bus.cs_n = 1'b0; bus.address_in = 4'd11; bus.data_in = 8'hFF;
        bus.IOR = 1'b0; bus.IOW = 1'b0;
        #1;
        obs("both_oe", 16'(bus.data_oe), 16'd0);
        obs("both_data", 16'(bus.data_out), 16'd0);
        tick(); tick();
        bus.IOR = 1'b1; bus.IOW = 1'b1; bus.cs_n = 1'b1; bus.data_in = '0;
        tick();
        ch_select = 2'd3;
        #1;
        obs("both_nowrite", 16'(mode_out), 16'd0);
        rd("rd_ptr_kept");

`ifdef MODE_LOCK_EN
        busy = 4'b1000;
        ch_select = 2'd3;
        wr(4'd11, 8'h47, 1);
        obs("lock_hold", 16'(mode_out), 16'd0);
        busy = 4'b0000;
        tick();
        obs("lock_apply", 16'(mode_out), 16'h11);
        busy = 4'b1000;
        wr(4'd11, 8'h17, 1);
        wr(4'd11, 8'h1B, 1);
        obs("lock_hold2", 16'(mode_out), 16'h11);
        busy = 4'b0000;
        tick();
        obs("lock_overwrite", 16'(mode_out), 16'h06);
        busy = 4'b1000;
        wr(4'd11, 8'h8B, 1);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        busy = 4'b0000;
        tick(); tick();
        obs("lock_rst_discard", 16'(mode_out), 16'd0);
`else
        busy = 4'b1111;
        ch_select = 2'd3;
        wr(4'd11, 8'h47, 1);
        obs("busy_ignored", 16'(mode_out), 16'h11);
        busy = 4'b0000;
`endif

        obs("sb_drained", 16'(sb_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dma_mode_regfile.md
Name: dma_mode_regfile

Overview:
- Parametrised per-channel mode register file for the DMA controller; successor to the fixed 4×6-bit mode store.
- CPU programs the mode register through the slave port (8237-style: channel in data low bits, mode in upper bits); supports master clear and sequential read-back.
- Supplies the active channel's mode word to the transfer FSM, including memory-to-memory source/destination selection.
- Generates the auto-initialize reload strobe on terminal count.

Parameters:
- NUM_CH, 4, number of channels (2..8)
- CH_W, $clog2(NUM_CH), channel index width
- MODE_W, 6, mode field width
- ADDR_W, 4, slave address width
- MODE_ADDR, 11, write mode / read-back address
- CLEAR_ADDR, 13, master-clear address
- RESET_MODE, 6'b000000, value loaded on reset and on master clear
- M2M_SRC_CH, 0, mem-to-mem source channel
- M2M_DST_CH, 1, mem-to-mem destination channel

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cs_n  in  1  chip select, active low
- address_in  in  ADDR_W  slave register address
- IOR  in  1  read strobe, active low
- IOW  in  1  write strobe, active low
- data_in  in  MODE_W+CH_W  write data; [CH_W-1:0] = channel, upper bits = mode
- data_out  out  MODE_W+CH_W  read-back data
- data_oe  out  1  high while read-back drives data_out
- ch_select  in  CH_W  channel currently serviced
- mem2mem  in  1  memory-to-memory transfer active
- flag_mem  in  1  1 = source (read) phase, 0 = destination phase
- tc  in  1  terminal-count pulse for the serviced channel
- busy  in  NUM_CH  per-channel transfer-in-progress (used only with MODE_LOCK_EN)
- mode_out  out  MODE_W  mode of the active channel
- autoinit_reload  out  1  one-cycle reload strobe

Behaviour:
- Reset (rst_n=0, asynchronous): all mode[i] = RESET_MODE; read pointer = 0; IOW/IOR edge flags cleared; autoinit_reload = 0; data_oe = 0.
- Write qualification: cs_n=0, IOW=0, IOR=1.
- Write to MODE_ADDR: mode[data_in[CH_W-1:0]] <= data_in[upper] on the first qualifying clk edge only. Edge-detect flag blocks further writes until IOW returns to 1, so one write per strobe regardless of strobe length.
- Channel index >= NUM_CH (non-power-of-2 NUM_CH): the write is ignored.
- Write to CLEAR_ADDR:
  - all mode[i] = RESET_MODE and read pointer = 0, same one-shot rule.
  - Data is ignored.
  - Takes priority over any pending or deferred write.
- Read-back: cs_n=0, IOR=0, IOW=1, address_in=MODE_ADDR.
  - data_oe = 1 and data_out = {mode[ptr], ptr}, combinational from registers.
  - ptr increments on the IOR 0→1 transition (registered detect) and wraps NUM_CH-1 → 0.
  - When not reading, data_oe = 0 and data_out = 0.
- Simultaneous IOR=0 and IOW=0: no write, no read, ptr unchanged.
- mode_out, combinational:
  - mem2mem=1: mode[M2M_SRC_CH] when flag_mem=1, mode[M2M_DST_CH] when flag_mem=0.
  - Otherwise: mode[ch_select].
- Mode layout: [1:0] transfer type, [2] autoinit, [3] address decrement, [5:4] service mode. Bits above 5 are stored but not interpreted.
- autoinit_reload:
  - Registered; asserts 1 cycle after a clk edge with tc=1 and mode_out[2]=1, for exactly 1 cycle per tc cycle.
  - tc held for N cycles gives N strobes; the FSM owns pulse shaping.
- A write to the active channel in the same cycle as tc: reload decision uses the pre-write mode.

Optional Feature:
- MODE_LOCK_EN defined:
  - A write targeting channel i while busy[i]=1 is held in a single pending slot (channel + mode).
  - The pending write is applied on the first clk edge with busy[i]=0.
  - A second write while a write is pending overwrites the slot.
  - Master clear or reset discards the pending write.
- MODE_LOCK_EN undefined: busy is ignored; writes apply immediately.

Decomposition:
- Shared package dma_pkg: mode bit-field index constants (MODE_TT_LSB, MODE_AUTOINIT, MODE_DEC, MODE_SVC_LSB), transfer-type and service-mode encodings, default MODE_ADDR/CLEAR_ADDR constants.
- One sub-module: dma_strobe_edge (per-strobe one-shot and release detector), instantiated for IOW and IOR.

Test Plan:
- Reset, then read back 4 times at MODE_ADDR → data_out = 0x00, 0x01, 0x02, 0x03; fifth read = 0x00 (wrap).
- Write data_in=8'hAA (ch2, mode 6'b101010) with IOW low for 5 cycles → mode[2]=0x2A written once; ch_select=2 → mode_out=6'b101010.
- mem2mem=1: write mode[0]=0x05, mode[1]=0x09 → flag_mem=1 gives mode_out=0x05; flag_mem=0 gives mode_out=0x09.
- Write mode[1]=0x04 (autoinit), ch_select=1, tc pulsed 1 cycle → autoinit_reload high exactly 1 cycle later. With mode 0x00, the same stimulus → no strobe.
- Program all channels, write CLEAR_ADDR mid read-back sequence (ptr=2) → all modes = RESET_MODE; next read returns 0x00.
- MODE_LOCK_EN: busy[3]=1, write ch3 mode 0x11 → mode[3] unchanged; drop busy[3] → mode[3]=0x11 next edge. Assert rst_n=0 while pending → write discarded.
